// File: rtl/fetch_inst_queue_pkg.sv
// rtl/fetch_inst_queue_pkg.sv - shared entry layout for the fetch instruction queue
package fetch_inst_queue_pkg;
  localparam int FQ_WORD_W    = 32;
  localparam int EXC_CAUSE_W  = 7;
  localparam int FQ_ENTRY_W   = 104;
  localparam int FQ_INST_LSB  = 0;
  localparam int FQ_PC_LSB    = 32;
  localparam int FQ_EXC_BIT   = 64;
  localparam int FQ_CAUSE_LSB = 65;
  localparam int FQ_PRED_LSB  = 72;

  function automatic logic [FQ_ENTRY_W-1:0] fq_pack(
    input logic [FQ_WORD_W-1:0]   inst,
    input logic [FQ_WORD_W-1:0]   pc,
    input logic                   exc,
    input logic [EXC_CAUSE_W-1:0] cause,
    input logic [FQ_WORD_W-1:0]   pred
  );
    return {pred, cause, exc, pc, inst};
  endfunction
endpackage

// File: rtl/fetch_inst_queue.sv
// rtl/fetch_inst_queue.sv - two-in/two-out instruction queue between icache and decode
module fetch_inst_queue
  import fetch_inst_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_flush,
  input  logic                   i_in_valid,
  input  logic [FQ_WORD_W-1:0]   i_in_inst1,
  input  logic [FQ_WORD_W-1:0]   i_in_inst2,
  input  logic [FQ_WORD_W-1:0]   i_in_pc1,
  input  logic [FQ_WORD_W-1:0]   i_in_pc2,
  input  logic                   i_in_exc1,
  input  logic                   i_in_exc2,
  input  logic [EXC_CAUSE_W-1:0] i_in_cause1,
  input  logic [EXC_CAUSE_W-1:0] i_in_cause2,
  input  logic [FQ_WORD_W-1:0]   i_in_pred_addr,
  output logic                   o_fq_stall,
  input  logic                   i_dec_ready,
  output logic                   o_out_valid1,
  output logic                   o_out_valid2,
  output logic [FQ_WORD_W-1:0]   o_out_inst1,
  output logic [FQ_WORD_W-1:0]   o_out_inst2,
  output logic [FQ_WORD_W-1:0]   o_out_pc1,
  output logic [FQ_WORD_W-1:0]   o_out_pc2,
  output logic                   o_out_exc1,
  output logic                   o_out_exc2,
  output logic [EXC_CAUSE_W-1:0] o_out_cause1,
  output logic [EXC_CAUSE_W-1:0] o_out_cause2,
  output logic [FQ_WORD_W-1:0]   o_out_pred1,
  output logic [FQ_WORD_W-1:0]   o_out_pred2,
  output logic [CW-1:0]          o_occupancy
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] LP_ACCEPT_MAX = CW'(DEPTH - 2);

  logic [FQ_ENTRY_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]         r_head;
  logic [PW-1:0]         r_tail;
  logic [CW-1:0]         r_count;

  logic                  w_in_ready;
  logic                  w_push;
  logic [1:0]            w_pop;
  logic [PW-1:0]         w_head1;
  logic [PW-1:0]         w_tail1;
  logic [FQ_ENTRY_W-1:0] w_e1;
  logic [FQ_ENTRY_W-1:0] w_e2;

  // Readiness looks only at the registered count so dec_ready never reaches fq_stall.
  assign w_in_ready = (r_count <= LP_ACCEPT_MAX);
  assign w_push     = i_in_valid & w_in_ready & ~i_flush;
  assign w_head1    = r_head + PW'(1);
  assign w_tail1    = r_tail + PW'(1);

  always_comb begin
    w_pop = 2'd0;
    if (i_dec_ready) begin
      if (r_count >= CW'(2))      w_pop = 2'd2;
      else if (r_count == CW'(1)) w_pop = 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PW'(w_pop);
      if (w_push) r_tail <= r_tail + PW'(2);
      r_count <= r_count + (w_push ? CW'(2) : CW'(0)) - CW'(w_pop);
    end
  end

  // Storage is intentionally left uncleared; validity comes from the count alone.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_mem[r_tail]  <= fq_pack(i_in_inst1, i_in_pc1, i_in_exc1, i_in_cause1, i_in_pred_addr);
      r_mem[w_tail1] <= fq_pack(i_in_inst2, i_in_pc2, i_in_exc2, i_in_cause2, i_in_pred_addr);
    end
  end

  assign w_e1 = r_mem[r_head];
  assign w_e2 = r_mem[w_head1];

  assign o_fq_stall   = ~w_in_ready;
  assign o_occupancy  = r_count;
  assign o_out_valid1 = (r_count >= CW'(1));
  assign o_out_valid2 = (r_count >= CW'(2));

  assign o_out_inst1  = w_e1[FQ_INST_LSB +: FQ_WORD_W];
  assign o_out_pc1    = w_e1[FQ_PC_LSB +: FQ_WORD_W];
  assign o_out_exc1   = w_e1[FQ_EXC_BIT];
  assign o_out_cause1 = w_e1[FQ_CAUSE_LSB +: EXC_CAUSE_W];
  assign o_out_pred1  = w_e1[FQ_PRED_LSB +: FQ_WORD_W];

  assign o_out_inst2  = w_e2[FQ_INST_LSB +: FQ_WORD_W];
  assign o_out_pc2    = w_e2[FQ_PC_LSB +: FQ_WORD_W];
  assign o_out_exc2   = w_e2[FQ_EXC_BIT];
  assign o_out_cause2 = w_e2[FQ_CAUSE_LSB +: EXC_CAUSE_W];
  assign o_out_pred2  = w_e2[FQ_PRED_LSB +: FQ_WORD_W];
endmodule
